// File: rtl/cint_pkg.sv
// Shared types and constants for the CINT sequencer.
// Optional bus-grant timeout is enabled by defining CINT_GNT_TIMEOUT_EN.
package cint_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PH1,
    PH2,
    PH3,
    DONE
  } state_t;

  localparam logic [2:0] PHASE_NONE = 3'b000;
  localparam logic [2:0] PHASE_P1   = 3'b001;
  localparam logic [2:0] PHASE_P2   = 3'b010;
  localparam logic [2:0] PHASE_P3   = 3'b100;

  localparam int unsigned VEC_SW = 0;

endpackage

// File: rtl/cint_prio_enc.sv
// Lowest-index-first priority encoder over the unmasked hardware requests.
module cint_prio_enc #(
  parameter int unsigned N_SRC = 4,
  parameter int unsigned IDX_W = 3
) (
  input  logic [N_SRC-1:0] i_req,
  output logic             o_valid,
  output logic [IDX_W-1:0] o_index,
  output logic [N_SRC-1:0] o_onehot
);

  assign o_valid  = |i_req;
  assign o_onehot = i_req & (~i_req + N_SRC'(1));

  // Scanning downward lets the lowest set bit be the last writer.
  always_comb begin
    o_index = '0;
    for (int unsigned i = N_SRC; i > 0; i--) begin
      if (i_req[i-1]) o_index = IDX_W'(i - 1);
    end
  end

endmodule

// File: rtl/cint_sequencer.sv
// CINT flow sequencer: arbitration, P1..P3 phase strobes, mode capture, vector push.
// Define CINT_GNT_TIMEOUT_EN to abort PH3 after a bounded wait for bus_gnt.
module cint_sequencer
  import cint_pkg::*;
#(
  parameter int unsigned N_SRC = 4,
  parameter int unsigned VEC_W = 3,
  parameter int unsigned TMO_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable_cint,
  input  logic             p2_reset_cint,
  input  logic             p2_set_rst,
  input  logic             p2_set_call,
  input  logic [N_SRC-1:0] irq,
  input  logic [N_SRC-1:0] irq_mask,
  input  logic             reti,
  input  logic             bus_gnt,
  output logic [2:0]       phase,
  output logic             busy,
  output logic             bus_req,
  output logic             mode_call,
  output logic [VEC_W-1:0] vector,
  output logic [N_SRC-1:0] ack,
  output logic             ie,
  output logic             done,
  output logic             err
);

  state_t r_state, w_next;

  logic             r_sw;
  logic             r_mode_call;
  logic             r_ie;
  logic [VEC_W-1:0] r_vector;
  logic [N_SRC-1:0] r_src_oh;

  logic [N_SRC-1:0] w_req;
  logic             w_hw_valid;
  logic [VEC_W-1:0] w_hw_idx;
  logic [N_SRC-1:0] w_hw_oh;
  logic             w_start;
  logic             w_mode_fail;
  logic             w_tmo_hit;

  assign w_req = irq & ~irq_mask;

  cint_prio_enc #(
    .N_SRC(N_SRC),
    .IDX_W(VEC_W)
  ) u_prio (
    .i_req   (w_req),
    .o_valid (w_hw_valid),
    .o_index (w_hw_idx),
    .o_onehot(w_hw_oh)
  );

  assign w_start     = enable_cint || (r_ie && w_hw_valid);
  assign w_mode_fail = r_sw && !(p2_set_call || p2_set_rst || p2_reset_cint);

`ifdef CINT_GNT_TIMEOUT_EN
  logic [TMO_W-1:0] r_tmo;
  logic [TMO_W-1:0] w_tmo_inc;

  assign w_tmo_inc = r_tmo + TMO_W'(1);
  assign w_tmo_hit = !bus_gnt && (w_tmo_inc == '1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  r_tmo <= '0;
    else if (r_state != PH3)  r_tmo <= '0;
    else if (!bus_gnt)        r_tmo <= w_tmo_inc;
  end
`else
  assign w_tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_start) w_next = PH1;
      PH1:  w_next = PH2;
      PH2:  w_next = w_mode_fail ? IDLE : PH3;
      PH3: begin
        if (bus_gnt)        w_next = DONE;
        else if (w_tmo_hit) w_next = IDLE;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Source/vector latched on leaving IDLE; ie set by reti outranks the DONE clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sw        <= 1'b0;
      r_vector    <= '0;
      r_src_oh    <= '0;
      r_mode_call <= 1'b0;
      r_ie        <= 1'b1;
    end else begin
      if (r_state == IDLE && w_start) begin
        r_sw     <= enable_cint;
        r_vector <= enable_cint ? VEC_W'(VEC_SW) : w_hw_idx + VEC_W'(1);
        r_src_oh <= enable_cint ? '0 : w_hw_oh;
      end
      if (r_state == PH2) begin
        if (!r_sw || p2_set_call) r_mode_call <= 1'b1;
        else if (p2_set_rst)      r_mode_call <= 1'b0;
      end
      if (reti)                  r_ie <= 1'b1;
      else if (r_state == DONE)  r_ie <= 1'b0;
    end
  end

  always_comb begin
    phase   = PHASE_NONE;
    bus_req = 1'b0;
    done    = 1'b0;
    err     = 1'b0;
    ack     = '0;
    case (r_state)
      PH1: phase = PHASE_P1;
      PH2: begin
        phase = PHASE_P2;
        err   = w_mode_fail;
      end
      PH3: begin
        phase   = PHASE_P3;
        bus_req = 1'b1;
        err     = w_tmo_hit;
      end
      DONE: begin
        done = 1'b1;
        ack  = r_sw ? '0 : r_src_oh;
      end
      default: ;
    endcase
  end

  assign busy      = (r_state != IDLE);
  assign mode_call = r_mode_call;
  assign vector    = r_vector;
  assign ie        = r_ie;

endmodule

// File: tb/tb_cint_sequencer.sv
// Self-checking bench for cint_sequencer: per-cycle model comparison plus directed literal checks.
module tb_cint_sequencer;

  localparam int unsigned N_SRC = 4;
  localparam int unsigned VEC_W = 3;
`ifdef CINT_GNT_TIMEOUT_EN
  localparam int unsigned TMO_W = 2;
`else
  localparam int unsigned TMO_W = 4;
`endif
  localparam int TMO_LIM = (1 << TMO_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             enable_cint = 1'b0;
  logic             p2_reset_cint = 1'b0;
  logic             p2_set_rst = 1'b0;
  logic             p2_set_call = 1'b0;
  logic [N_SRC-1:0] irq = '0;
  logic [N_SRC-1:0] irq_mask = '0;
  logic             reti = 1'b0;
  logic             bus_gnt = 1'b0;
  logic [2:0]       phase;
  logic             busy, bus_req, mode_call, ie, done, err;
  logic [VEC_W-1:0] vector;
  logic [N_SRC-1:0] ack;

  cint_sequencer #(
    .N_SRC(N_SRC),
    .VEC_W(VEC_W),
    .TMO_W(TMO_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable_cint  (enable_cint),
    .p2_reset_cint(p2_reset_cint),
    .p2_set_rst   (p2_set_rst),
    .p2_set_call  (p2_set_call),
    .irq          (irq),
    .irq_mask     (irq_mask),
    .reti         (reti),
    .bus_gnt      (bus_gnt),
    .phase        (phase),
    .busy         (busy),
    .bus_req      (bus_req),
    .mode_call    (mode_call),
    .vector       (vector),
    .ack          (ack),
    .ie           (ie),
    .done         (done),
    .err          (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: m_pos counts progress through a transaction (0 idle, 1..3 phase steps, 4 completion).
  int m_pos  = 0;
  bit m_sw   = 0;
  int m_src  = 0;
  bit m_mode = 0;
  bit m_ie   = 1;
  int m_vec  = 0;
  int m_wait = 0;

  always @(posedge clk or posedge rst) begin
    bit ie_n;
    if (rst) begin
      m_pos = 0; m_sw = 0; m_src = 0; m_mode = 0; m_ie = 1; m_vec = 0; m_wait = 0;
    end else begin
      ie_n = reti ? 1'b1 : ((m_pos == 4) ? 1'b0 : m_ie);
      case (m_pos)
        0: begin
          if (enable_cint) begin
            m_sw = 1; m_vec = 0; m_pos = 1;
          end else if (m_ie && ((irq & ~irq_mask) != '0)) begin
            m_sw = 0;
            for (int s = N_SRC - 1; s >= 0; s--) if (irq[s] && !irq_mask[s]) m_src = s;
            m_vec = m_src + 1;
            m_pos = 1;
          end
        end
        1: m_pos = 2;
        2: begin
          if (!m_sw || p2_set_call) m_mode = 1;
          else if (p2_set_rst)      m_mode = 0;
          m_pos  = (m_sw && !(p2_set_call || p2_set_rst || p2_reset_cint)) ? 0 : 3;
          m_wait = 0;
        end
        3: begin
          if (bus_gnt) m_pos = 4;
          else begin
            m_wait++;
`ifdef CINT_GNT_TIMEOUT_EN
            if (m_wait == TMO_LIM) m_pos = 0;
`endif
          end
        end
        default: m_pos = 0;
      endcase
      m_ie = ie_n;
    end
  end

  always @(negedge clk) begin
    logic [2:0]       e_phase;
    logic [N_SRC-1:0] e_ack;
    logic             e_err;
    e_phase = (m_pos >= 1 && m_pos <= 3) ? 3'(1 << (m_pos - 1)) : 3'b000;
    e_ack   = (m_pos == 4 && !m_sw) ? N_SRC'(1 << m_src) : '0;
    e_err   = (m_pos == 2) && m_sw && !(p2_set_call || p2_set_rst || p2_reset_cint);
`ifdef CINT_GNT_TIMEOUT_EN
    if (m_pos == 3 && !bus_gnt && (m_wait + 1 == TMO_LIM)) e_err = 1'b1;
`endif
    chk("m_phase",   phase,     e_phase);
    chk("m_busy",    busy,      m_pos != 0);
    chk("m_bus_req", bus_req,   m_pos == 3);
    chk("m_done",    done,      m_pos == 4);
    chk("m_ack",     ack,       e_ack);
    chk("m_err",     err,       e_err);
    chk("m_mode",    mode_call, m_mode);
    chk("m_vector",  vector,    m_vec);
    chk("m_ie",      ie,        m_ie);
  end

  logic [2:0] T1_PH [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b000};
  logic [2:0] MT_P2 [4] = '{3'b010, 3'b001, 3'b110, 3'b010};  // {call, rst, reset_cint}
  logic       MT_MODE [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

  int lat, cnt, cyc, err_at, n_err, seen_breq, seen_done;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // The software request is held only until the sequencer accepts it.
  task automatic wait_done(input string nm, output int l);
    int c;
    c = 0;
    do begin
      @(negedge clk);
      c++;
      if (busy) enable_cint = 1'b0;
    end while (!done && c < 60);
    chk({nm, "_done"}, done, 1'b1);
    l = c - 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("rst_ie", ie, 1'b1);
    chk("rst_phase", phase, 3'b000);
    chk("rst_busy", busy, 1'b0);

    // Software CALL with immediate grant
    tick();
    enable_cint = 1'b1; p2_set_call = 1'b1; bus_gnt = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (busy) enable_cint = 1'b0;
      chk($sformatf("sw_call_phase%0d", k), phase, T1_PH[k]);
    end
    chk("sw_call_done_c4", done, 1'b1);
    chk("sw_call_vector", vector, 0);
    chk("sw_call_mode", mode_call, 1'b1);
    chk("sw_call_ack", ack, 4'b0000);
    @(negedge clk);
    chk("sw_call_ie_cleared", ie, 1'b0);
    chk("sw_call_idle", busy, 1'b0);

    // Mode selection table
    for (int i = 0; i < 4; i++) begin
      tick();
      enable_cint = 1'b1;
      {p2_set_call, p2_set_rst, p2_reset_cint} = MT_P2[i];
      wait_done($sformatf("mode%0d", i), lat);
      chk($sformatf("mode%0d_mode", i), mode_call, MT_MODE[i]);
      chk($sformatf("mode%0d_lat", i), lat, 4);
    end
    tick();
    {p2_set_call, p2_set_rst, p2_reset_cint} = 3'b000;

    // Hardware priority with masking
    reti = 1'b1;
    tick();
    reti = 1'b0; irq = 4'b0110; irq_mask = 4'b0010;
    wait_done("hw_prio", lat);
    chk("hw_prio_lat", lat, 4);
    chk("hw_prio_vector", vector, 3);
    chk("hw_prio_ack", ack, 4'b0100);
    chk("hw_prio_mode", mode_call, 1'b1);
    irq = '0; irq_mask = '0;

    // Simultaneous software and hardware
    tick();
    reti = 1'b1;
    tick();
    reti = 1'b0; irq = 4'b0001; enable_cint = 1'b1; p2_set_call = 1'b1;
    wait_done("simul_sw", lat);
    chk("simul_sw_vector", vector, 0);
    chk("simul_sw_ack", ack, 4'b0000);
    tick();
    tick();
    @(negedge clk);
    chk("simul_hold_ie0", busy, 1'b0);
    tick();
    reti = 1'b1;
    wait_done("simul_hw", lat);
    chk("simul_hw_vector", vector, 1);
    chk("simul_hw_ack", ack, 4'b0001);
    irq = '0;
    tick();
    reti = 1'b0;
    @(negedge clk);
    chk("reti_beats_clear", ie, 1'b1);

    // Mode failure: no decoder pulse
    tick();
    p2_set_call = 1'b0; enable_cint = 1'b1; bus_gnt = 1'b1;
    err_at = -1; n_err = 0; seen_breq = 0; seen_done = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (busy) enable_cint = 1'b0;
      if (err) begin n_err++; if (err_at < 0) err_at = k; end
      if (bus_req) seen_breq = 1;
      if (done) seen_done = 1;
    end
    chk("fail_err_cycle", err_at, 2);
    chk("fail_err_count", n_err, 1);
    chk("fail_no_bus_req", seen_breq, 0);
    chk("fail_no_done", seen_done, 0);
    chk("fail_idle", busy, 1'b0);

`ifdef CINT_GNT_TIMEOUT_EN
    // Grant timeout
    tick();
    enable_cint = 1'b1; p2_set_call = 1'b1; bus_gnt = 1'b0;
    cnt = 0; cyc = 0; n_err = 0; seen_done = 0;
    while (n_err == 0 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (busy) enable_cint = 1'b0;
      if (bus_req) cnt++;
      if (err) n_err++;
      if (done) seen_done = 1;
    end
    chk("tmo_err", n_err, 1);
    chk("tmo_ph3_cycles", cnt, TMO_LIM);
    chk("tmo_no_done", seen_done, 0);
    chk("tmo_no_ack", ack, 4'b0000);
    @(negedge clk);
    chk("tmo_idle", busy, 1'b0);
    chk("tmo_ie_kept", ie, 1'b1);
`else
    // Grant wait: five cycles without grant
    tick();
    enable_cint = 1'b1; p2_set_call = 1'b1; bus_gnt = 1'b0;
    cnt = 0; cyc = 0;
    while (!done && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (busy) enable_cint = 1'b0;
      if (bus_req) cnt++;
      if (cnt == 5 && !bus_gnt) begin
        @(posedge clk);
        #2 bus_gnt = 1'b1;
      end
    end
    chk("gwait_done", done, 1'b1);
    chk("gwait_bus_req_cycles", cnt, 6);
    chk("gwait_no_err", err, 1'b0);
`endif

    // Async reset in the middle of PH3
    tick();
    enable_cint = 1'b1; p2_set_call = 1'b1; bus_gnt = 1'b0;
    cyc = 0;
    while (!bus_req && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (busy) enable_cint = 1'b0;
    end
    chk("mid_ph3_reached", bus_req, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("arst_phase", phase, 3'b000);
    chk("arst_busy", busy, 1'b0);
    chk("arst_bus_req", bus_req, 1'b0);
    chk("arst_ie", ie, 1'b1);
    chk("arst_mode", mode_call, 1'b0);
    chk("arst_vector", vector, 0);
    chk("arst_flags", {done, err, ack}, 0);
    tick();
    tick();
    rst = 1'b0; p2_set_call = 1'b0;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cint_sequencer.md
Name: cint_sequencer

Overview:
- Multi-cycle controller that sequences the CINT (call-interrupt) flow around the CINT0 decoder.
- Arbitrates between the software CINT request (decoder enable) and N masked hardware interrupt lines.
- Drives one-hot phase strobes P1..P3 and samples the decoder's phase-2 reset/set pulses to fix the entry mode (RST or CALL).
- Requests the vector-push bus cycle, then reports completion and the taken vector to the core.

Parameters:
N_SRC, 4, number of hardware interrupt sources (2..8)
VEC_W, 3, width of vector number output
TMO_W, 4, width of bus-grant timeout counter (used only with feature)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
enable_cint  in  1  software CINT decoded (level, held while instruction is current)
p2_reset_cint  in  1  decoder phase-2 reset-CINT pulse
p2_set_rst  in  1  decoder phase-2 select RST entry
p2_set_call  in  1  decoder phase-2 select CALL entry
irq  in  N_SRC  hardware interrupt levels, bit 0 highest priority
irq_mask  in  N_SRC  1 = source masked
reti  in  1  return-from-interrupt pulse, re-enables interrupts
bus_gnt  in  1  vector-push bus grant
phase  out  3  one-hot {P3,P2,P1}, 000 when idle
busy  out  1  sequencer not in IDLE
bus_req  out  1  vector-push bus request
mode_call  out  1  latched entry mode, 1 = CALL, 0 = RST
vector  out  VEC_W  taken vector: 0 = software, src+1 = hardware
ack  out  N_SRC  one-hot acknowledge to taken hardware source, 1-cycle pulse
ie  out  1  global interrupt enable
done  out  1  1-cycle completion pulse
err  out  1  1-cycle abort pulse

Behaviour:
- Reset (async): state IDLE; phase=000; busy=0; bus_req=0; mode_call=0; vector=0; ack=0; ie=1; done=0; err=0.
- States: IDLE, PH1, PH2, PH3, DONE.
- IDLE:
  - enable_cint=1 → PH1 with vector=0. Software wins over hardware in the same cycle, and is taken regardless of ie.
  - Else if ie=1 and (irq & ~irq_mask)≠0 → PH1. The lowest set bit wins; vector=index+1.
- PH1: phase=001. Source and vector latched on entry and frozen until IDLE. Next state PH2 unconditionally.
- PH2: phase=010. Decoder pulses are sampled here only; they are ignored in every other state.
  - Software with p2_set_call → mode_call=1.
  - Software with p2_set_rst → mode_call=0.
  - Software with both → CALL wins.
  - Software with neither → err pulse and return to IDLE; no done, ack or bus_req.
  - p2_reset_cint is accepted and counted as a valid entry (mode unchanged).
  - Hardware source: mode_call forced to 1 and decoder pulses ignored.
  - Next state PH3.
- PH3: phase=100. bus_req=1 from the first PH3 cycle.
  - Held until the cycle bus_gnt=1 is sampled; bus_req drops in that same cycle's transition → DONE.
  - Zero-wait grant gives PH3 length 1.
- DONE: phase=000; done=1 for one cycle; ack bit of the hardware source=1 for one cycle; ie←0. Next state IDLE.
- Latency: request to done = 4 cycles with immediate grant.
- ie: set by reti in any state. If reti coincides with the DONE clear, the set wins.
- Requests arriving while busy are not queued. Hardware levels are re-evaluated in IDLE; enable_cint must still be high.
- Masking or dropping the winning irq after PH1 does not abort the sequence.
- bus_req never asserts outside PH3.

Optional Feature:
- Macro CINT_GNT_TIMEOUT_EN.
- With it: a TMO_W-bit counter clears on PH3 entry and increments each PH3 cycle without grant. On reaching all-ones without grant: err pulse, bus_req drops, state → IDLE, ie unchanged, no ack.
- Without it: PH3 waits indefinitely. err is raised only by the PH2 mode failure.

Decomposition:
- Package cint_pkg: state enum (IDLE, PH1, PH2, PH3, DONE), one-hot phase constants, vector value for software (0).
- Sub-module cint_prio_enc: combinational lowest-index-first priority encoder on irq & ~irq_mask. Outputs valid, index, one-hot.

Test Plan:
- Software CALL: enable_cint=1, p2_set_call in PH2, bus_gnt tied 1 → phase 001,010,100, done at cycle 4, vector=0, mode_call=1, ack=0, ie=0.
- Hardware priority: irq=0110, mask=0010, ie=1 → source 2 taken, vector=3, mode_call=1, ack=0100 pulse with done.
- Simultaneous: enable_cint=1 and irq=0001 in the same IDLE cycle → software taken (vector=0). After done and reti, hardware is taken next (vector=1).
- Mode failure: software entry with no p2 pulse → err pulse leaving PH2, back to IDLE, bus_req never high.
- Grant wait: bus_gnt low for 5 cycles → bus_req high for 6 cycles, done follows the grant. With CINT_GNT_TIMEOUT_EN and TMO_W=2 and bus_gnt held low → err after 3 PH3 cycles.
- Async reset mid-PH3 → all outputs at reset values immediately, ie=1, bus_req=0.
